axi_master_controller: RTL and testbench

Single-outstanding AXI4-Lite master bridge. It converts one simple load/store request from a requester (instruction/data cache) on the controller-side request interface into one AXI4-Lite read or write transaction on the bus-side interface. It returns the load data and completion status to the requester. It sits between the caches and the AXI interconnect or slave controllers (RAM/ROM).

---
 rtl/axi_master_controller.sv | 199 +++++++++++++++++++
 tb/tb_axi_master_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_controller.sv
// Single-outstanding AXI4-Lite master: one load/store request becomes one AR/R or AW/W/B transaction.
// Latency 3 cycles request-to-ready minimum, +1 per slave stall cycle; requests are ignored until ready has pulsed.
module axi_master_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  read,
    input  logic [1:0]            write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     store,
    output logic                  ready,
    output logic [DATA_W-1:0]     load,
    output logic                  error,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp
);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [ADDR_W-1:0]    araddr_q, araddr_d;
    logic [ADDR_W-1:0]    awaddr_q, awaddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    load_q, load_d;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        ready_d   = 1'b0;
        error_d   = error_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        load_d    = load_q;

        case (state_q)
            S_IDLE: begin
                if (write != 2'b00) begin
                    state_d   = S_WREQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = addr;
                    // Sub-word data is replicated across lanes so the strobe alone selects the bytes.
                    case (write)
                        2'b01: begin
                            wdata_d = {4{store[7:0]}};
                            wstrb_d = 4'b0001 << addr[1:0];
                        end
                        2'b10: begin
                            wdata_d = {2{store[15:0]}};
                            wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            wdata_d = store;
                            wstrb_d = 4'b1111;
                        end
                    endcase
                end else if (read) begin
                    state_d   = S_RADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = addr;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    load_d   = rdata;
                    error_d  = (rresp != 2'b00);
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_WREQ: begin
                // AW and W complete independently; each valid drops on its own handshake.
                aw_done_d = aw_done_q | (awvalid_q & awready);
                w_done_d  = w_done_q | (wvalid_q & wready);
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    error_d  = (bresp != 2'b00);
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            load_q    <= load_d;
        end
    end

    assign ready   = ready_q;
    assign load    = load_q;
    assign error   = error_q;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign arprot  = 3'b000;
    assign rready  = rready_q;
    assign awvalid = awvalid_q;
    assign awaddr  = awaddr_q;
    assign awprot  = 3'b000;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_axi_master_controller.sv
// Bench for axi_master_controller: directed scenarios plus randomized traffic against a lane/latency model.
module tb_axi_master_controller;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  write = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] store = '0;
    logic        ready;
    logic [31:0] load;
    logic        error;
    logic        arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = '0;

    int checks = 0;
    int errors = 0;

    int          obs_lat, obs_ready_cnt;
    logic        obs_timeout, obs_ar_used, obs_aw_used;
    logic        obs_ar_unstable, obs_aw_unstable, obs_w_unstable;
    logic        obs_bready_early, obs_wdrop_aw_hold, obs_prot_bad;
    logic [31:0] obs_araddr, obs_awaddr, obs_wdata, obs_load;
    logic [3:0]  obs_wstrb;
    logic        obs_err;

    axi_master_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .read(read), .write(write), .addr(addr), .store(store),
        .ready(ready), .load(load), .error(error),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: an access of n bytes occupies the naturally aligned n-byte lane group
    // containing addr; each lane carries store byte (lane mod n).
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int n, off;
        n   = 1 << (int'(sz) - 1);
        off = (int'(a[1:0]) / n) * n;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] st);
        int n;
        logic [31:0] d;
        n = 1 << (int'(sz) - 1);
        d = '0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = st[8*(i % n) +: 8];
        return d;
    endfunction

    // Plays requester and slave for one transaction; records what the DUT did.
    task automatic run_txn(input logic rd, input logic [1:0] wr, input logic [31:0] a,
                           input logic [31:0] st, input int ar_dly, input int r_dly,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [31:0] rdat, input logic [1:0] resp);
        int ar_seen, r_seen, aw_seen, w_seen, b_seen, cyc;
        logic done;
        ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0; cyc = 0; done = 1'b0;
        obs_lat = 0; obs_ready_cnt = 0; obs_timeout = 1'b0;
        obs_ar_used = 1'b0; obs_aw_used = 1'b0; obs_ar_unstable = 1'b0;
        obs_aw_unstable = 1'b0; obs_w_unstable = 1'b0; obs_bready_early = 1'b0;
        obs_wdrop_aw_hold = 1'b0; obs_prot_bad = 1'b0;
        obs_araddr = '0; obs_awaddr = '0; obs_wdata = '0; obs_wstrb = '0;
        obs_load = '0; obs_err = 1'b0;
        @(negedge clk);
        read = rd; write = wr; addr = a; store = st;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                addr  = $urandom;
                store = $urandom;
            end
            if (arprot !== 3'b000 || awprot !== 3'b000) obs_prot_bad = 1'b1;
            if (arvalid) begin
                obs_ar_used = 1'b1;
                if (ar_seen == 0) obs_araddr = araddr;
                else if (araddr !== obs_araddr) obs_ar_unstable = 1'b1;
                ar_seen++;
            end
            arready = arvalid && (ar_seen > ar_dly);
            if (rready) r_seen++;
            rvalid = rready && (r_seen > r_dly);
            rdata  = rvalid ? rdat : $urandom;
            rresp  = rvalid ? resp : 2'($urandom);
            if (awvalid) begin
                obs_aw_used = 1'b1;
                if (aw_seen == 0) obs_awaddr = awaddr;
                else if (awaddr !== obs_awaddr) obs_aw_unstable = 1'b1;
                aw_seen++;
            end
            awready = awvalid && (aw_seen > aw_dly);
            if (wvalid) begin
                if (w_seen == 0) begin
                    obs_wdata = wdata;
                    obs_wstrb = wstrb;
                end else if (wdata !== obs_wdata || wstrb !== obs_wstrb) obs_w_unstable = 1'b1;
                w_seen++;
            end
            wready = wvalid && (w_seen > w_dly);
            if (awvalid && !wvalid && w_seen > 0) obs_wdrop_aw_hold = 1'b1;
            if (bready && (awvalid || wvalid)) obs_bready_early = 1'b1;
            if (bready && (aw_seen == 0 || w_seen == 0)) obs_bready_early = 1'b1;
            if (bready) b_seen++;
            bvalid = bready && (b_seen > b_dly);
            bresp  = bvalid ? resp : 2'($urandom);
            if (ready) begin
                done = 1'b1;
                obs_lat = cyc;
                obs_load = load;
                obs_err = error;
                obs_ready_cnt = 1;
                read = 1'b0;
                write = 2'b00;
            end
        end
        obs_timeout = !done;
        read = 1'b0; write = 2'b00;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) obs_ready_cnt++;
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids got %b exp 000000", {arvalid, awvalid, wvalid, rready, bready, ready});
        end
        checks++;
        if ({load, error, araddr, awaddr, wdata, wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_data got load=%h err=%b ar=%h aw=%h wd=%h ws=%b exp all 0",
                     load, error, araddr, awaddr, wdata, wstrb);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, ready} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 000000", {arvalid, awvalid, wvalid, rready, bready, ready});
        end
    endtask

    task automatic test_word_read;
        run_txn(1'b1, 2'b00, 32'h40, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00);
        checks++;
        if (obs_timeout !== 1'b0) begin errors++; $display("FAIL word_read_timeout got 1 exp 0"); end
        checks++;
        if (obs_araddr !== 32'h40) begin errors++; $display("FAIL word_read_araddr got %h exp 00000040", obs_araddr); end
        checks++;
        if (obs_lat != 3) begin errors++; $display("FAIL word_read_latency got %0d exp 3", obs_lat); end
        checks++;
        if (obs_ready_cnt != 1) begin errors++; $display("FAIL word_read_pulses got %0d exp 1", obs_ready_cnt); end
        checks++;
        if (obs_load !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL word_read_data got load=%h err=%b exp DEADBEEF/0", obs_load, obs_err);
        end
    endtask

    task automatic test_stalled_read;
        run_txn(1'b1, 2'b00, 32'h0000_1234, 32'h0, 4, 3, 0, 0, 0, 32'hCAFE_F00D, 2'b00);
        checks++;
        if (obs_lat != 10) begin errors++; $display("FAIL stalled_read_latency got %0d exp 10", obs_lat); end
        checks++;
        if (obs_ar_unstable !== 1'b0 || obs_araddr !== 32'h1234) begin
            errors++;
            $display("FAIL stalled_read_ar got addr=%h unstable=%b exp 00001234/0", obs_araddr, obs_ar_unstable);
        end
        checks++;
        if (obs_ready_cnt != 1 || obs_load !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL stalled_read_resp got pulses=%0d load=%h exp 1/CAFEF00D", obs_ready_cnt, obs_load);
        end
    endtask

    task automatic test_byte_write;
        run_txn(1'b0, 2'b01, 32'h803, 32'h0000_00A5, 0, 0, 0, 0, 0, 32'h0, 2'b00);
        checks++;
        if (obs_awaddr !== 32'h803) begin errors++; $display("FAIL byte_write_awaddr got %h exp 00000803", obs_awaddr); end
        checks++;
        if (obs_wdata !== 32'hA5A5A5A5 || obs_wstrb !== 4'b1000) begin
            errors++;
            $display("FAIL byte_write_w got wdata=%h wstrb=%b exp A5A5A5A5/1000", obs_wdata, obs_wstrb);
        end
        checks++;
        if (obs_lat != 3 || obs_ready_cnt != 1) begin
            errors++;
            $display("FAIL byte_write_timing got lat=%0d pulses=%0d exp 3/1", obs_lat, obs_ready_cnt);
        end
    endtask

    task automatic test_half_skew;
        run_txn(1'b0, 2'b10, 32'h802, 32'h0000_1234, 0, 0, 2, 0, 1, 32'h0, 2'b00);
        checks++;
        if (obs_wdata !== 32'h12341234 || obs_wstrb !== 4'b1100) begin
            errors++;
            $display("FAIL half_write_w got wdata=%h wstrb=%b exp 12341234/1100", obs_wdata, obs_wstrb);
        end
        checks++;
        if (obs_wdrop_aw_hold !== 1'b1 || obs_aw_unstable !== 1'b0) begin
            errors++;
            $display("FAIL half_write_skew got wdrop=%b awunstable=%b exp 1/0", obs_wdrop_aw_hold, obs_aw_unstable);
        end
        checks++;
        if (obs_bready_early !== 1'b0) begin errors++; $display("FAIL half_write_bready_early got 1 exp 0"); end
        checks++;
        if (obs_lat != 6 || obs_ready_cnt != 1) begin
            errors++;
            $display("FAIL half_write_timing got lat=%0d pulses=%0d exp 6/1", obs_lat, obs_ready_cnt);
        end
    endtask

    task automatic test_error;
        run_txn(1'b1, 2'b00, 32'h80, 32'h0, 0, 0, 0, 0, 0, 32'h1111_2222, 2'b10);
        checks++;
        if (obs_err !== 1'b1 || obs_ready_cnt != 1) begin
            errors++;
            $display("FAIL slverr_read got err=%b pulses=%0d exp 1/1", obs_err, obs_ready_cnt);
        end
        run_txn(1'b1, 2'b00, 32'h84, 32'h0, 0, 0, 0, 0, 0, 32'h3333_4444, 2'b00);
        checks++;
        if (obs_err !== 1'b0 || obs_load !== 32'h3333_4444) begin
            errors++;
            $display("FAIL okay_after_err got err=%b load=%h exp 0/33334444", obs_err, obs_load);
        end
        run_txn(1'b0, 2'b11, 32'h88, 32'h5555_6666, 0, 0, 0, 0, 0, 32'h0, 2'b11);
        checks++;
        if (obs_err !== 1'b1) begin errors++; $display("FAIL decerr_write got err=%b exp 1", obs_err); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        logic seen_rready;
        pulses = 0;
        seen_rready = 1'b0;
        @(negedge clk);
        read = 1'b1; addr = 32'h100;
        arready = 1'b0; rvalid = 1'b0;
        for (int i = 0; i < 10 && !seen_rready; i++) begin
            @(negedge clk);
            arready = arvalid;
            if (rready) seen_rready = 1'b1;
        end
        checks++;
        if (seen_rready !== 1'b1) begin errors++; $display("FAIL reset_mid_reach_rdata got 0 exp 1"); end
        read = 1'b0; arready = 1'b0;
        nrst = 1'b0;
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, ready, error, load, araddr, awaddr, wdata, wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got v=%b ar=%h exp all 0",
                     {arvalid, awvalid, wvalid, rready, bready, ready}, araddr);
        end
        @(negedge clk);
        nrst = 1'b1;
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; bvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ready || arvalid || rready) pulses++;
        end
        rvalid = 1'b0; bvalid = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", pulses); end
    endtask

    task automatic test_priority;
        run_txn(1'b1, 2'b11, 32'h0000_2000, 32'h89AB_CDEF, 0, 0, 0, 0, 0, 32'h0, 2'b00);
        checks++;
        if (obs_aw_used !== 1'b1 || obs_ar_used !== 1'b0) begin
            errors++;
            $display("FAIL priority_channel got aw=%b ar=%b exp 1/0", obs_aw_used, obs_ar_used);
        end
        checks++;
        if (obs_wdata !== 32'h89AB_CDEF || obs_wstrb !== 4'b1111 || obs_awaddr !== 32'h2000) begin
            errors++;
            $display("FAIL priority_word got wd=%h ws=%b aw=%h exp 89ABCDEF/1111/00002000",
                     obs_wdata, obs_wstrb, obs_awaddr);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic        is_wr;
            logic [1:0]  sz, resp;
            logic [31:0] a, st, rd;
            int          d0, d1, d2, exp_lat;
            is_wr = 1'($urandom);
            sz    = 2'($urandom_range(3, 1));
            resp  = 2'($urandom);
            a     = $urandom;
            st    = $urandom;
            rd    = $urandom;
            d0    = $urandom_range(3, 0);
            d1    = $urandom_range(3, 0);
            d2    = $urandom_range(3, 0);
            if (is_wr) begin
                run_txn(1'($urandom), sz, a, st, 0, 0, d0, d1, d2, 32'h0, resp);
                exp_lat = 3 + ((d0 > d1) ? d0 : d1) + d2;
                checks++;
                if (obs_awaddr !== a || obs_wdata !== exp_wdata(sz, st) || obs_wstrb !== exp_strb(sz, a)) begin
                    errors++;
                    $display("FAIL rand_write[%0d] got aw=%h wd=%h ws=%b exp %h/%h/%b", t,
                             obs_awaddr, obs_wdata, obs_wstrb, a, exp_wdata(sz, st), exp_strb(sz, a));
                end
                checks++;
                if (obs_aw_unstable || obs_w_unstable || obs_bready_early || obs_ar_used) begin
                    errors++;
                    $display("FAIL rand_write_proto[%0d] got awu=%b wu=%b be=%b ar=%b exp 0000", t,
                             obs_aw_unstable, obs_w_unstable, obs_bready_early, obs_ar_used);
                end
            end else begin
                run_txn(1'b1, 2'b00, a, st, d0, d1, 0, 0, 0, rd, resp);
                exp_lat = 3 + d0 + d1;
                checks++;
                if (obs_araddr !== a || obs_load !== rd || obs_ar_unstable || obs_aw_used) begin
                    errors++;
                    $display("FAIL rand_read[%0d] got ar=%h load=%h aru=%b aw=%b exp %h/%h/0/0", t,
                             obs_araddr, obs_load, obs_ar_unstable, obs_aw_used, a, rd);
                end
            end
            checks++;
            if (obs_timeout || obs_lat != exp_lat || obs_ready_cnt != 1 || obs_err !== (resp != 2'b00)
                || obs_prot_bad) begin
                errors++;
                $display("FAIL rand_resp[%0d] got to=%b lat=%0d pulses=%0d err=%b prot=%b exp 0/%0d/1/%b/0", t,
                         obs_timeout, obs_lat, obs_ready_cnt, obs_err, obs_prot_bad, exp_lat, resp != 2'b00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_stalled_read();
        test_byte_write();
        test_half_skew();
        test_error();
        test_reset_mid();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
